imm_encoder: RTL and testbench

- Inverse of the decode-side immediate generator: packs a signed 32-bit immediate plus register and function fields into an RV32I instruction word.
- Supported formats: I, S, B, J, U.
- Used by the debug/boot instruction-injection path to build instructions before they are written into instruction memory.
- Two-stage pipeline with valid/ready handshakes on both sides, per-word range checking, and a saturating error counter.

---
 rtl/imm_encoder.sv | 127 ++++++++++++
 tb/tb_imm_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: packs a signed immediate plus register/function fields
// into an instruction word through a two-stage valid/ready pipeline.
module imm_encoder #(
    parameter int          ERR_CNT_W = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [31:0]          in_imm,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_J = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    // Handshake: a word moves across a boundary on the rising edge where the
    // sender's valid and the receiver's ready are both high; valid never waits on ready.
    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [31:0] s1_imm;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [2:0]  s1_funct3;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic        s1_err;

    logic        s2_load;
    logic        err1;
    logic [31:0] packed_word;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Immediate must be representable by the sign-extended field of its format.
    always_comb begin
        err1 = 1'b1;
        case (in_fmt)
            FMT_I, FMT_S: err1 = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            FMT_B:        err1 = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            FMT_J:        err1 = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            FMT_U:        err1 = |in_imm[11:0];
            default:      err1 = 1'b1;
        endcase
    end

    always_comb begin
        packed_word = NOP_INSTR;
        case (s1_fmt)
            FMT_I: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                                  s1_imm[4:0], s1_opcode};
            FMT_B: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                  s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_J: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                  s1_rd, s1_opcode};
            FMT_U: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
            default: packed_word = NOP_INSTR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= 3'd0;
            s1_imm    <= 32'd0;
            s1_opcode <= 7'd0;
            s1_rd     <= 5'd0;
            s1_funct3 <= 3'd0;
            s1_rs1    <= 5'd0;
            s1_rs2    <= 5'd0;
            s1_err    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= in_fmt;
                s1_imm    <= in_imm;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_funct3 <= in_funct3;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_err    <= err1;
            end
        end
    end

    // Output word and error flag only change when the stage loads, so they
    // hold steady through backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= packed_word;
                    out_err   <= s1_err;
                end
            end
            if (out_valid && out_ready && out_err && (err_count != CNT_MAX))
                err_count <= err_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, backpressure,
// counter saturation, async reset, and randomized traffic against an arithmetic model.
module tb_imm_encoder;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready, s_in_ready;
    logic [2:0]  in_fmt = 0;
    logic [31:0] in_imm = 0;
    logic [6:0]  in_opcode = 0;
    logic [4:0]  in_rd = 0;
    logic [2:0]  in_funct3 = 0;
    logic [4:0]  in_rs1 = 0;
    logic [4:0]  in_rs2 = 0;
    logic        out_valid, s_out_valid;
    logic        out_ready = 1;
    logic [31:0] out_instr, s_out_instr;
    logic        out_err, s_out_err;
    logic [15:0] err_count;
    logic [1:0]  s_err_count;

    int total = 0;
    int bad = 0;
    int cnt_big = 0;
    int cnt_small = 0;
    int n_out = 0;
    bit rand_mode = 0;
    logic [32:0] exp_q[$];
    vec_t tbl[7];

    imm_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .err_count(err_count)
    );

    imm_encoder #(.ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_fmt(in_fmt), .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
        .out_err(s_out_err), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int len);
        return (v >> lo) & ((32'd1 << len) - 32'd1);
    endfunction

    // Reference: range from signed bounds, word assembled as weighted bit fields.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int s = signed'(v.imm);
        logic [31:0] base;
        base = ({25'd0, v.op}) + ({27'd0, v.rd} << 7) + ({29'd0, v.f3} << 12)
             + ({27'd0, v.rs1} << 15);
        case (v.fmt)
            3'd0: begin
                r.err = (s < -2048) || (s > 2047);
                r.instr = base + (fld(v.imm, 0, 12) << 20);
            end
            3'd1: begin
                r.err = (s < -2048) || (s > 2047);
                r.instr = base - ({27'd0, v.rd} << 7) + ({27'd0, v.rs2} << 20)
                        + (fld(v.imm, 5, 7) << 25) + (fld(v.imm, 0, 5) << 7);
            end
            3'd2: begin
                r.err = (s < -4096) || (s > 4095) || (v.imm % 2 != 0);
                r.instr = base - ({27'd0, v.rd} << 7) + ({27'd0, v.rs2} << 20)
                        + (fld(v.imm, 12, 1) << 31) + (fld(v.imm, 5, 6) << 25)
                        + (fld(v.imm, 1, 4) << 8) + (fld(v.imm, 11, 1) << 7);
            end
            3'd3: begin
                r.err = (s < -1048576) || (s > 1048575) || (v.imm % 2 != 0);
                r.instr = {25'd0, v.op} + ({27'd0, v.rd} << 7)
                        + (fld(v.imm, 20, 1) << 31) + (fld(v.imm, 1, 10) << 21)
                        + (fld(v.imm, 11, 1) << 20) + (fld(v.imm, 12, 8) << 12);
            end
            3'd4: begin
                r.err = (v.imm % 4096) != 0;
                r.instr = (v.imm - v.imm % 4096) + {25'd0, v.op} + ({27'd0, v.rd} << 7);
            end
            default: begin
                r.err = 1'b1;
                r.instr = 32'h0000_0013;
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input vec_t v);
        in_fmt = v.fmt; in_imm = v.imm; in_opcode = v.op; in_rd = v.rd;
        in_funct3 = v.f3; in_rs1 = v.rs1; in_rs2 = v.rs2;
    endtask

    task automatic send(input vec_t v);
        bit ok = 0;
        drive(v);
        in_valid = 1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({v.err, v.instr});
                ok = 1;
            end
            tick();
        end
        in_valid = 0;
        check("send_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) tick();
        tick();
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1;
        exp_q.delete();
        cnt_big = 0;
        cnt_small = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("err_count", {16'd0, err_count}, cnt_big);
            check("err_count_w2", {30'd0, s_err_count}, cnt_small);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_instr, 32'hxxxx_xxxx);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    n_out++;
                    check("out_instr", out_instr, e[31:0]);
                    check("out_err", {31'd0, out_err}, {31'd0, e[32]});
                    check("out_instr_w2", s_out_instr, e[31:0]);
                    check("out_err_w2", {31'd0, s_out_err}, {31'd0, e[32]});
                    if (e[32]) begin
                        cnt_big++;
                        if (cnt_small < 3) cnt_small++;
                    end
                end
            end
        end
    end

    initial begin
        vec_t a, b, c, v;
        int n0;
        tbl[0] = '{3'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFF0_0093, 1'b0};
        tbl[1] = '{3'd2, 32'hFFFF_FFFC, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'hFE20_8EE3, 1'b0};
        tbl[2] = '{3'd3, 32'h0000_0800, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0010_00EF, 1'b0};
        tbl[3] = '{3'd4, 32'h1234_5000, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_52B7, 1'b0};
        tbl[4] = '{3'd0, 32'h0000_0800, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'h8000_0093, 1'b1};
        tbl[5] = '{3'd2, 32'h0000_0003, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'h0000_0163, 1'b1};
        tbl[6] = '{3'd6, 32'h0000_0000, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 32'h0000_0013, 1'b1};

        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // I-type latency
        send(tbl[0]);
        @(negedge clk);
        check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_cycle2", {31'd0, out_valid}, 32'd1);
        drain();

        // B then J back to back
        send(tbl[1]);
        send(tbl[2]);
        @(negedge clk);
        check("b2b_first", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        check("b2b_second", {31'd0, out_valid}, 32'd1);
        drain();

        for (int i = 3; i < 7; i++) send(tbl[i]);
        drain();
        check("err_count_3", {16'd0, err_count}, 32'd3);

        // Backpressure with three offered words
        a = model('{3'd0, 32'd5, 7'h13, 5'd3, 3'd1, 5'd2, 5'd0, 32'd0, 1'b0});
        b = model('{3'd1, 32'hFFFF_FFFC, 7'h23, 5'd0, 3'd2, 5'd4, 5'd9, 32'd0, 1'b0});
        c = model('{3'd4, 32'hABCD_E000, 7'h17, 5'd7, 3'd0, 5'd0, 5'd0, 32'd0, 1'b0});
        n0 = n_out;
        out_ready = 0;
        drive(a); in_valid = 1;
        @(negedge clk);
        check("bp_ready_a", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({a.err, a.instr});
        tick();
        drive(b);
        @(negedge clk);
        check("bp_ready_b", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({b.err, b.instr});
        tick();
        drive(c);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_full", {31'd0, in_ready}, 32'd0);
            check("bp_full_w2", {31'd0, s_in_ready}, 32'd0);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_instr", out_instr, a.instr);
            tick();
        end
        out_ready = 1;
        @(negedge clk);
        check("bp_ready_c", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({c.err, c.instr});
        tick();
        in_valid = 0;
        drain();
        check("bp_count", n_out - n0, 32'd3);

        // Randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 200; i++) begin
            v.fmt = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: v.imm = $urandom;
                1: v.imm = 32'(signed'(13'($urandom)));
                2: v.imm = $urandom & 32'hFFFF_F000;
                default: v.imm = 32'(signed'(21'($urandom))) & 32'hFFFF_FFFE;
            endcase
            v.op = 7'($urandom); v.rd = 5'($urandom); v.f3 = 3'($urandom);
            v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
            send(model(v));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_mode = 0;
        out_ready = 1;
        drain();

        // Counter saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(model('{3'd7, 32'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b0}));
            drain();
            check("sat_w2", {30'd0, s_err_count}, (k < 3) ? k + 1 : 3);
            check("sat_w16", {16'd0, err_count}, k + 1);
        end

        // Asynchronous reset with both stages occupied
        out_ready = 0;
        send(model('{3'd5, 32'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b0}));
        a = model('{3'd0, 32'd12, 7'h13, 5'd2, 3'd0, 5'd1, 5'd0, 32'd0, 1'b0});
        drive(a); in_valid = 1;
        @(negedge clk);
        check("mid_accept", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({a.err, a.instr});
        tick();
        in_valid = 0;
        @(negedge clk);
        check("mid_out_valid", {31'd0, out_valid}, 32'd1);
        check("mid_out_err", {31'd0, out_err}, 32'd1);
        check("mid_s1_full", {31'd0, in_ready}, 32'd0);
        check("mid_err_count", {16'd0, err_count}, 32'd5);
        #2;
        rst = 1;
        exp_q.delete();
        cnt_big = 0;
        cnt_small = 0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_err", {31'd0, out_err}, 32'd0);
        check("arst_out_instr", out_instr, 32'd0);
        check("arst_err_count", {16'd0, err_count}, 32'd0);
        check("arst_err_count_w2", {30'd0, s_err_count}, 32'd0);
        @(posedge clk);
        #1 rst = 0;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1;
        send(tbl[2]);
        drain();
        check("final_queue", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
